// File: rtl/core_mdu.sv
`timescale 1ns/1ps
// Iterative radix-2 multiply/divide unit for the RV32M operations, generalised to XLEN.
// Handshake: START is accepted only when BUSY=0 and FLUSH=0; DONE pulses one cycle with RESULT valid.
module core_mdu #(
  parameter int XLEN             = 32,
  parameter bit DIV_FAST_SPECIAL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [1:0]      o_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_neg;
  logic            r_sign_a;
  logic [XLEN-1:0] r_result;

  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic            w_b_zero, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic [XLEN:0]   w_sum, w_rem_sh;
  logic [XLEN-1:0] w_diff, w_rem_next;
  logic            w_q_bit;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_quo, w_rem, w_fix;

  // Operand signedness: MULHSU treats only rs1 as signed, U-variants neither.
  assign w_is_div = i_funct3[2];
  assign w_sgn_a  = w_is_div ? !i_funct3[0] : (i_funct3[1:0] != 2'b11);
  assign w_sgn_b  = w_is_div ? !i_funct3[0] : !i_funct3[1];
  assign w_neg_a  = w_sgn_a & i_op_a[XLEN-1];
  assign w_neg_b  = w_sgn_b & i_op_b[XLEN-1];
  assign w_mag_a  = w_neg_a ? -i_op_a : i_op_a;
  assign w_mag_b  = w_neg_b ? -i_op_b : i_op_b;
  assign w_b_zero = (i_op_b == '0);
  assign w_ovf    = w_sgn_a & (i_op_a == MIN_NEG) & (i_op_b == '1);
  assign w_fast   = DIV_FAST_SPECIAL & w_is_div & (w_b_zero | w_ovf);
  assign w_accept = i_start & !i_flush & ((r_state == S_IDLE) | (r_state == S_DONE));

  // Multiply step: conditional add into the high word, then shift {carry,hi,lo} right.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);

  // Restoring divide step; the shifted partial remainder carries one guard bit.
  assign w_rem_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_q_bit    = (w_rem_sh >= {1'b0, r_op});
  assign w_diff     = w_rem_sh[XLEN-1:0] - r_op;
  assign w_rem_next = w_q_bit ? w_diff : w_rem_sh[XLEN-1:0];

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo    = r_neg ? -r_lo : r_lo;
  assign w_rem    = r_sign_a ? -r_hi : r_hi;
  assign w_fix    = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                  : ((r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_f3     <= i_funct3;
            r_cnt    <= '0;
            r_neg    <= (w_neg_a ^ w_neg_b) & (!w_is_div | !w_b_zero);
            r_sign_a <= w_neg_a;
            r_op     <= w_is_div ? w_mag_b : w_mag_a;
            // Special divides preload the final quotient/remainder magnitudes and skip CALC.
            if (w_fast) begin
              r_hi    <= w_b_zero ? w_mag_a : '0;
              r_lo    <= w_b_zero ? '1 : MIN_NEG;
              r_state <= S_FIX;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_mag_a : w_mag_b;
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (r_f3[2]) begin
            r_hi <= w_rem_next;
            r_lo <= {r_lo[XLEN-2:0], w_q_bit};
          end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == LAST_STEP) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fix;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state == S_CALC) | (r_state == S_FIX);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_state  = r_state;

endmodule

// File: tb/tb_core_mdu.sv
`timescale 1ns/1ps
// Bench for core_mdu: one instance with the fast special-case path and one without,
// driven by the same stimulus and checked against an arithmetic reference model.
module tb_core_mdu;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        nrst, start, flush;
  logic [2:0]  f3;
  logic [31:0] op_a, op_b;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  core_mdu #(.XLEN(XLEN), .DIV_FAST_SPECIAL(1'b1)) u_fast (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_funct3(f3), .i_op_a(op_a), .i_op_b(op_b),
    .i_flush(flush), .o_busy(busy0), .o_done(done0), .o_result(res0), .o_state(st0));

  core_mdu #(.XLEN(XLEN), .DIV_FAST_SPECIAL(1'b0)) u_slow (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_funct3(f3), .i_op_a(op_a), .i_op_b(op_b),
    .i_flush(flush), .o_busy(busy1), .o_done(done1), .o_result(res1), .o_state(st1));

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M-extension rules expressed with 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sub = $signed(ub);
    ia  = a;
    ib  = b;
    case (fn)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * sub; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    return fn[2] && ((b == 0) || (!fn[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN_NEG;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: latency is counted in edges from the accept edge to the edge that samples DONE.
  task automatic mon(input int idx, input logic done, input logic busy, input logic [31:0] res);
    exp_t e;
    int   n;
    if (done) begin
      check(idx == 0 ? "fast_busy_with_done" : "slow_busy_with_done", {31'd0, busy}, 32'd0);
      n = (idx == 0) ? exp_q0.size() : exp_q1.size();
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done dut%0d: got result %h, expected no DONE (cycle %0d)", idx, res, cyc);
      end else begin
        if (idx == 0) e = exp_q0.pop_front();
        else          e = exp_q1.pop_front();
        check(idx == 0 ? "fast_result" : "slow_result", res, e.res);
        check(idx == 0 ? "fast_latency" : "slow_latency", 32'(cyc + 1) - e.acc, e.lat);
        last_res = e.res;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, done0, busy0, res0);
    mon(1, done1, busy1, res1);
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while ((busy0 || busy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: got busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] r;
    int ac;
    wait_ready();
    f3 = fn; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    ac = cyc;
    r  = model(fn, a, b);
    exp_q0.push_back('{res: r, lat: (is_special(fn, a, b) ? 32'd2 : 32'(XLEN + 2)), acc: 32'(ac)});
    exp_q1.push_back('{res: r, lat: 32'(XLEN + 2), acc: 32'(ac)});
    // START stays high while the operands keep changing; the DUT must ignore them.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      op_a = $urandom();
      op_b = $urandom();
      f3   = 3'($urandom_range(0, 7));
    end
    start = 1'b0;
  endtask

  logic [2:0]  dir_f3 [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] dir_a  [12] = '{32'd7, MIN_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd7, 32'd7, MIN_NEG, MIN_NEG};
  logic [31:0] dir_b  [12] = '{32'hFFFF_FFFD, MIN_NEG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    nrst = 1'b0; start = 1'b0; flush = 1'b0; f3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy0", {31'd0, busy0}, 32'd0);
    check("reset_done0", {31'd0, done0}, 32'd0);
    check("reset_result0", res0, 32'd0);
    check("reset_busy1", {31'd0, busy1}, 32'd0);
    check("reset_done1", {31'd0, done1}, 32'd0);
    check("reset_result1", res1, 32'd0);
    nrst = 1'b1;

    // Directed operations, issued back to back.
    for (int i = 0; i < 12; i++) issue(dir_f3[i], dir_a[i], dir_b[i], 0);

    // START held high with changing operands after acceptance.
    issue(3'd0, $urandom(), $urandom(), 20);
    issue(3'd4, $urandom(), 32'($urandom_range(1, 50)), 20);

    // FLUSH partway through a DIV: no DONE, RESULT unchanged.
    issue(3'd4, 32'd1000, 32'd7, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(exp_q0.pop_back());
    void'(exp_q1.pop_back());
    @(negedge clk);
    check("flush_busy0", {31'd0, busy0}, 32'd0);
    check("flush_busy1", {31'd0, busy1}, 32'd0);
    check("flush_result0", res0, last_res);
    check("flush_result1", res1, last_res);
    repeat (40) @(negedge clk);
    check("flush_hold_result0", res0, last_res);
    check("flush_hold_result1", res1, last_res);

    // FLUSH together with START in IDLE: not accepted.
    f3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy0", {31'd0, busy0}, 32'd0);
    check("flush_start_busy1", {31'd0, busy1}, 32'd0);

    // Reset in the middle of a MUL.
    issue(3'd0, $urandom(), $urandom(), 0);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    void'(exp_q0.pop_back());
    void'(exp_q1.pop_back());
    last_res = '0;
    @(negedge clk);
    check("midreset_busy0", {31'd0, busy0}, 32'd0);
    check("midreset_done0", {31'd0, done0}, 32'd0);
    check("midreset_result0", res0, 32'd0);
    check("midreset_busy1", {31'd0, busy1}, 32'd0);
    check("midreset_done1", {31'd0, done1}, 32'd0);
    check("midreset_result1", res1, 32'd0);
    issue(3'd0, 32'd3, 32'd5, 0);

    // Randomized operations with corner-biased operands.
    for (int i = 0; i < 40; i++) issue(3'($urandom_range(0, 7)), pick_op(), pick_op(), 0);

    n = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0", exp_q0.size(), exp_q1.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
